led_pattern_sequencer: RTL and testbench
========================================

# led_pattern_sequencer

Sequences the PMOD LED bank from the on-chip oscillator clock: a prescaler derives a step tick from the free-running oscillator output, and a mode state machine advances one of four LED patterns on each tick. It sits between the oscillator wrapper (clock source) and the PMOD LED pins, with a button input to cycle modes and a pause input to freeze the display.

## Interface
- CLK_HZ, 2_100_000, frequency of `clk` in Hz (oscillator output with divider 100)
- STEP_HZ, 10, pattern step rate in Hz; DIV = CLK_HZ/STEP_HZ (integer), DIV >= 2 required
- LED_NUM, 8, number of LEDs driven, >= 2
- clk  input  1  oscillator clock, all logic on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- mode_next  input  1  asynchronous button level, active-high; each rising edge advances the mode
- pause  input  1  asynchronous level, active-high; freezes prescaler and pattern
- led  output  LED_NUM  LED drive, active-high, registered
- step_tick  output  1  one-cycle pulse coinciding with each pattern step
- mode_o  output  2  current mode, registered

## Operation
- Reset values: led = 1 (only bit 0 set), mode_o = 0, step_tick = 0, prescaler cnt = 0, bounce pos = 0, dir = up, sync flops = 0.
- mode_next and pause each pass through a 2-flop synchronizer; mode_next has a third flop for rising-edge detect (edge = s2 & ~s3).
- Prescaler cnt: width clog2(DIV); when not paused, cnt increments; at cnt == DIV-1 it returns to 0 and a step occurs. When paused, cnt holds and no step occurs.
- Modes (wrap 3 -> 0 on edge):
  - 0 RUN: initial led = 1; step rotates left, bit LED_NUM-1 wraps to bit 0.
  - 1 BOUNCE: single lit LED at pos; initial pos 0, dir up; pos steps ±1; at pos LED_NUM-1 dir flips to down, at pos 0 flips to up. Sequence 0,1,…,LED_NUM-1,LED_NUM-2,…,0,1; period 2*(LED_NUM-1) steps.
  - 2 COUNT: initial led = 0; step adds 1 modulo 2^LED_NUM.
  - 3 BLINK: initial led all-ones; step inverts all bits.
- Mode change: on a detected edge, mode_o increments, led/pos/dir load the new mode's initial value, cnt clears to 0, step_tick stays 0 that cycle.
- Mode edge while paused: mode still changes and reloads; pattern stays frozen at the initial value until pause releases.

## Timing
- Step: on the clk edge where cnt == DIV-1 (not paused), cnt -> 0, step_tick -> 1 and led -> next value in the same edge; step_tick returns to 0 on the following edge. Steps are exactly DIV cycles apart while unpaused and mode unchanged.
- mode_next rising (setup met before edge E1): mode_o and reloaded led visible after edge E3 (3-cycle latency); holding mode_next high produces only one change.
- Simultaneous mode edge and cnt == DIV-1: mode change wins, no step, no step_tick; next step DIV cycles later.
- pause rising before E1: takes effect at E3; cnt value at that edge is frozen; release resumes counting from the frozen value with the same 2-cycle sync latency.
- rst_n low at any time: all registers take reset values immediately (asynchronously); release synchronized externally; first step DIV cycles after the first active edge.

## Test plan
- Reset/run (CLK_HZ=100, STEP_HZ=10 -> DIV=10, LED_NUM=8): release reset -> led=0x01, first step_tick 10 cycles later with led=0x02; after 8 steps led=0x01 again.
- Bounce: pulse mode_next once -> mode_o=1 exactly 3 edges later, led=0x01; 14 steps give 0x02,0x04,…,0x80,0x40,…,0x01; step 15 -> 0x02.
- Count and blink: advance to mode 2 -> led=0x00, after 255 steps 0xFF, step 256 -> 0x00; mode 3 -> led=0xFF, next step 0x00, then 0xFF; one more edge -> mode_o=0, led=0x01.
- Collision: assert mode_next so its detected edge lands on the cnt==9 cycle -> no step_tick that cycle, mode changes, next step_tick exactly 10 cycles later.
- Pause: assert pause mid-count (cnt=4) -> led and cnt frozen for 50 cycles, no step_tick; release -> next step 6 cycles after pause takes effect again (plus 2-cycle sync).
- Reset mid-operation: drop rst_n while in mode 1, pos=5 -> led=0x01, mode_o=0, step_tick=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// PMOD LED pattern sequencer: prescaled step tick drives one of four LED patterns,
// with a synchronized mode button (edge-detected) and a synchronized pause level.
`timescale 1ns/1ps

module led_pattern_sequencer #(
    parameter int CLK_HZ  = 2_100_000,
    parameter int STEP_HZ = 10,
    parameter int LED_NUM = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode_next,
    input  logic               pause,
    output logic [LED_NUM-1:0] led,
    output logic               step_tick,
    output logic [1:0]         mode_o
);

    localparam int DIV   = CLK_HZ / STEP_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int POS_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [POS_W-1:0]   POS_MAX  = POS_W'(LED_NUM - 1);
    localparam logic [POS_W-1:0]   POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0]   POS_ZERO = {POS_W{1'b0}};
    localparam logic [LED_NUM-1:0] LED_ONE  = {{(LED_NUM-1){1'b0}}, 1'b1};
    localparam logic [LED_NUM-1:0] LED_ZERO = {LED_NUM{1'b0}};
    localparam logic [LED_NUM-1:0] LED_ALL  = {LED_NUM{1'b1}};

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    // Pattern each mode starts from when it is entered.
    function automatic logic [LED_NUM-1:0] init_led(input mode_e m);
        logic [LED_NUM-1:0] v;
        case (m)
            MODE_RUN:    v = LED_ONE;
            MODE_BOUNCE: v = LED_ONE;
            MODE_COUNT:  v = LED_ZERO;
            MODE_BLINK:  v = LED_ALL;
            default:     v = LED_ONE;
        endcase
        return v;
    endfunction

    logic               mode_s1_r, mode_s2_r, mode_s3_r;
    logic               pause_s1_r, pause_s2_r;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    mode_e              mode_r, mode_s;
    logic [POS_W-1:0]   pos_r, pos_s, pos_step_s;
    logic               dir_up_r, dir_up_s;
    logic [LED_NUM-1:0] led_r, led_s;
    logic               tick_r, tick_s;
    logic               mode_edge_s;
    logic               paused_s;

    assign mode_edge_s = mode_s2_r & ~mode_s3_r;
    assign paused_s    = pause_s2_r;

    // Input synchronizers for the button and pause levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_r  <= 1'b0;
            mode_s2_r  <= 1'b0;
            mode_s3_r  <= 1'b0;
            pause_s1_r <= 1'b0;
            pause_s2_r <= 1'b0;
        end else begin
            mode_s1_r  <= mode_next;
            mode_s2_r  <= mode_s1_r;
            mode_s3_r  <= mode_s2_r;
            pause_s1_r <= pause;
            pause_s2_r <= pause_s1_r;
        end
    end

    // Mode, prescaler and pattern state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r   <= MODE_RUN;
            cnt_r    <= CNT_ZERO;
            pos_r    <= POS_ZERO;
            dir_up_r <= 1'b1;
            led_r    <= LED_ONE;
            tick_r   <= 1'b0;
        end else begin
            mode_r   <= mode_s;
            cnt_r    <= cnt_s;
            pos_r    <= pos_s;
            dir_up_r <= dir_up_s;
            led_r    <= led_s;
            tick_r   <= tick_s;
        end
    end

    // Next state: a mode edge outranks pause, and both outrank a pending step.
    always_comb begin
        mode_s     = mode_r;
        cnt_s      = cnt_r;
        pos_s      = pos_r;
        dir_up_s   = dir_up_r;
        led_s      = led_r;
        tick_s     = 1'b0;
        pos_step_s = dir_up_r ? (pos_r + POS_ONE) : (pos_r - POS_ONE);

        if (mode_edge_s) begin
            mode_s   = mode_e'(mode_r + 2'd1);
            led_s    = init_led(mode_s);
            pos_s    = POS_ZERO;
            dir_up_s = 1'b1;
            cnt_s    = CNT_ZERO;
        end else if (paused_s) begin
            cnt_s = cnt_r;
        end else if (cnt_r == CNT_MAX) begin
            cnt_s  = CNT_ZERO;
            tick_s = 1'b1;
            case (mode_r)
                MODE_RUN: begin
                    led_s = {led_r[LED_NUM-2:0], led_r[LED_NUM-1]};
                end
                MODE_BOUNCE: begin
                    pos_s = pos_step_s;
                    led_s = LED_ONE << pos_step_s;
                    if (pos_step_s == POS_MAX) begin
                        dir_up_s = 1'b0;
                    end else if (pos_step_s == POS_ZERO) begin
                        dir_up_s = 1'b1;
                    end else begin
                        dir_up_s = dir_up_r;
                    end
                end
                MODE_COUNT: begin
                    led_s = led_r + LED_ONE;
                end
                MODE_BLINK: begin
                    led_s = ~led_r;
                end
                default: begin
                    led_s = led_r;
                end
            endcase
        end else begin
            cnt_s = cnt_r + CNT_ONE;
        end
    end

    assign led       = led_r;
    assign step_tick = tick_r;
    assign mode_o    = mode_r;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (DIV = 10, 8 LEDs): per-feature
// tasks plus a scoreboard that checks the LED value on every step_tick.
`timescale 1ns/1ps

module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_next;
    logic       pause;
    logic [7:0] led;
    logic       step_tick;
    logic [1:0] mode_o;

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         sb_en   = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_exp;

    led_pattern_sequencer #(
        .CLK_HZ (100),
        .STEP_HZ(10),
        .LED_NUM(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_next(mode_next),
        .pause    (pause),
        .led      (led),
        .step_tick(step_tick),
        .mode_o   (mode_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: each step pops the expected LED value.
    always @(negedge clk) begin
        if (sb_en && rst_n && step_tick === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_step: led=%h with no step expected", led);
            end else begin
                sb_exp = exp_q.pop_front();
                if (led !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_step_led: got %h exp %h", led, sb_exp);
                end
            end
        end
    end

    task automatic wait_tick(input int max, output int cycles);
        cycles = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (step_tick === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_drain(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) ok = 1'b1;
        end
        sb_en = 1'b0;
        exp_q.delete();
    endtask

    // Raises mode_next at a falling edge and observes mode after E2 and E3.
    task automatic mode_edge(output logic [1:0] m_e2, output logic [1:0] m_e3,
                             output logic [7:0] l_e3, output logic t_e3);
        mode_next = 1'b1;
        @(negedge clk);
        @(negedge clk);
        m_e2 = mode_o;
        @(negedge clk);
        m_e3 = mode_o;
        l_e3 = led;
        t_e3 = step_tick;
    endtask

    task automatic test_reset();
        int c;
        bit ok;
        rst_n = 1'b0; mode_next = 1'b0; pause = 1'b0;
        #23;
        n_tests++; if (led !== 8'h01) begin n_fail++; $display("FAIL reset_led: got %h exp 01", led); end
        n_tests++; if (mode_o !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d exp 0", mode_o); end
        n_tests++; if (step_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b exp 0", step_tick); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < 8; i++) exp_q.push_back(8'h01 << i);
        exp_q.push_back(8'h01);
        sb_en = 1'b1;
        wait_tick(20, c);
        n_tests++; if (c !== 10) begin n_fail++; $display("FAIL run_first_step: got %0d cycles exp 10", c); end
        wait_drain(100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL run_drain: got timeout exp 8 steps"); end
    endtask

    task automatic test_bounce();
        logic [1:0] m2, m3;
        logic [7:0] l3;
        logic t3;
        bit ok;
        mode_edge(m2, m3, l3, t3);
        mode_next = 1'b0;
        n_tests++; if (m2 !== 2'd0) begin n_fail++; $display("FAIL bounce_latency_e2: got %0d exp 0", m2); end
        n_tests++; if (m3 !== 2'd1) begin n_fail++; $display("FAIL bounce_mode_e3: got %0d exp 1", m3); end
        n_tests++; if (l3 !== 8'h01) begin n_fail++; $display("FAIL bounce_init_led: got %h exp 01", l3); end
        n_tests++; if (t3 !== 1'b0) begin n_fail++; $display("FAIL bounce_change_tick: got %b exp 0", t3); end
        for (int i = 1; i <= 7; i++) exp_q.push_back(8'h01 << i);
        for (int i = 6; i >= 0; i--) exp_q.push_back(8'h01 << i);
        exp_q.push_back(8'h02);
        sb_en = 1'b1;
        wait_drain(180, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bounce_drain: got timeout exp 15 steps"); end
    endtask

    task automatic test_count_blink();
        logic [1:0] m2, m3;
        logic [7:0] l3;
        logic t3;
        bit ok;
        mode_edge(m2, m3, l3, t3);
        n_tests++; if (m3 !== 2'd2) begin n_fail++; $display("FAIL count_mode: got %0d exp 2", m3); end
        n_tests++; if (l3 !== 8'h00) begin n_fail++; $display("FAIL count_init_led: got %h exp 00", l3); end
        for (int i = 1; i <= 256; i++) exp_q.push_back(8'(i));
        sb_en = 1'b1;
        wait_drain(2700, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL count_drain: got timeout exp 256 steps"); end
        n_tests++; if (mode_o !== 2'd2) begin n_fail++; $display("FAIL count_hold_once: got %0d exp 2", mode_o); end
        mode_next = 1'b0;
        repeat (4) @(negedge clk);
        mode_edge(m2, m3, l3, t3);
        n_tests++; if (m3 !== 2'd3) begin n_fail++; $display("FAIL blink_mode: got %0d exp 3", m3); end
        n_tests++; if (l3 !== 8'hFF) begin n_fail++; $display("FAIL blink_init_led: got %h exp ff", l3); end
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        sb_en = 1'b1;
        wait_drain(40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL blink_drain: got timeout exp 2 steps"); end
        n_tests++; if (mode_o !== 2'd3) begin n_fail++; $display("FAIL blink_hold_once: got %0d exp 3", mode_o); end
        mode_next = 1'b0;
        repeat (4) @(negedge clk);
        mode_edge(m2, m3, l3, t3);
        mode_next = 1'b0;
        n_tests++; if (m3 !== 2'd0) begin n_fail++; $display("FAIL wrap_mode: got %0d exp 0", m3); end
        n_tests++; if (l3 !== 8'h01) begin n_fail++; $display("FAIL wrap_led: got %h exp 01", l3); end
    endtask

    task automatic test_collision();
        int c;
        mode_next = 1'b0;
        repeat (4) @(negedge clk);
        wait_tick(20, c);
        n_tests++; if (c < 0) begin n_fail++; $display("FAIL coll_align: got timeout exp a step"); end
        repeat (7) @(negedge clk);
        mode_next = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (mode_o !== 2'd0) begin n_fail++; $display("FAIL coll_pre_mode: got %0d exp 0", mode_o); end
        @(negedge clk);
        n_tests++; if (step_tick !== 1'b0) begin n_fail++; $display("FAIL coll_no_tick: got %b exp 0", step_tick); end
        n_tests++; if (mode_o !== 2'd1) begin n_fail++; $display("FAIL coll_mode: got %0d exp 1", mode_o); end
        n_tests++; if (led !== 8'h01) begin n_fail++; $display("FAIL coll_led: got %h exp 01", led); end
        mode_next = 1'b0;
        wait_tick(20, c);
        n_tests++; if (c !== 10) begin n_fail++; $display("FAIL coll_next_step: got %0d cycles exp 10", c); end
        n_tests++; if (led !== 8'h02) begin n_fail++; $display("FAIL coll_next_led: got %h exp 02", led); end
    endtask

    task automatic test_pause();
        int c;
        bit bad;
        wait_tick(20, c);
        n_tests++; if (c !== 10) begin n_fail++; $display("FAIL pause_pre_step: got %0d cycles exp 10", c); end
        n_tests++; if (led !== 8'h04) begin n_fail++; $display("FAIL pause_pre_led: got %h exp 04", led); end
        repeat (2) @(negedge clk);
        pause = 1'b1;
        repeat (2) @(negedge clk);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (step_tick !== 1'b0 || led !== 8'h04) bad = 1'b1;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL pause_frozen: got change or step, exp led 04 held"); end
        pause = 1'b0;
        wait_tick(20, c);
        n_tests++; if (c !== 8) begin n_fail++; $display("FAIL pause_resume: got %0d cycles exp 8", c); end
        n_tests++; if (led !== 8'h08) begin n_fail++; $display("FAIL pause_resume_led: got %h exp 08", led); end
    endtask

    task automatic test_reset_mid();
        int c;
        wait_tick(20, c);
        n_tests++; if (led !== 8'h10) begin n_fail++; $display("FAIL mid_pos4: got %h exp 10", led); end
        wait_tick(20, c);
        n_tests++; if (led !== 8'h20) begin n_fail++; $display("FAIL mid_pos5: got %h exp 20", led); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (led !== 8'h01) begin n_fail++; $display("FAIL async_led: got %h exp 01", led); end
        n_tests++; if (mode_o !== 2'd0) begin n_fail++; $display("FAIL async_mode: got %0d exp 0", mode_o); end
        n_tests++; if (step_tick !== 1'b0) begin n_fail++; $display("FAIL async_tick: got %b exp 0", step_tick); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(20, c);
        n_tests++; if (c !== 10) begin n_fail++; $display("FAIL mid_restart: got %0d cycles exp 10", c); end
        n_tests++; if (led !== 8'h02) begin n_fail++; $display("FAIL mid_restart_led: got %h exp 02", led); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_count_blink();
        test_collision();
        test_pause();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
